// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter with valid/ready load port,
// frame-start and last-bit markers, and clock-enable gating.
module piso_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic [WIDTH-1:0] Din,
  input  logic             Load_valid,
  output logic             Load_ready,
  output logic             Sout,
  output logic             Sout_valid,
  output logic             Frame_start,
  output logic             Last,
  output logic             Busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             load_bit;
  logic [WIDTH-1:0] load_rest;
  logic             next_bit;
  logic [WIDTH-1:0] sreg_next;

  // Ready only when the line is free this edge: idle, or last bit out.
  assign Load_ready = En & ~Rst &
                      ((state == IDLE) |
                       ((state == SHIFT) & (cnt == '0)));
  assign accept = Load_valid & Load_ready;

  // Shift register holds the bits still to be sent, next one at the head.
  always_comb begin
    if (MSB_FIRST) begin
      load_bit  = Din[WIDTH-1];
      load_rest = {Din[WIDTH-2:0], 1'b0};
      next_bit  = sreg[WIDTH-1];
      sreg_next = {sreg[WIDTH-2:0], 1'b0};
    end else begin
      load_bit  = Din[0];
      load_rest = {1'b0, Din[WIDTH-1:1]};
      next_bit  = sreg[0];
      sreg_next = {1'b0, sreg[WIDTH-1:1]};
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= IDLE;
      sreg        <= '0;
      cnt         <= '0;
      Sout        <= IDLE_LEVEL;
      Sout_valid  <= 1'b0;
      Frame_start <= 1'b0;
      Last        <= 1'b0;
      Busy        <= 1'b0;
    end else if (En) begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state       <= SHIFT;
            sreg        <= load_rest;
            cnt         <= CNT_TOP;
            Sout        <= load_bit;
            Sout_valid  <= 1'b1;
            Frame_start <= 1'b1;
            Last        <= 1'b0;
            Busy        <= 1'b1;
          end else begin
            Sout        <= IDLE_LEVEL;
            Sout_valid  <= 1'b0;
            Frame_start <= 1'b0;
            Last        <= 1'b0;
            Busy        <= 1'b0;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            sreg        <= sreg_next;
            cnt         <= cnt - CNT_ONE;
            Sout        <= next_bit;
            Frame_start <= 1'b0;
            Last        <= (cnt == CNT_ONE);
          end else if (accept) begin
            sreg        <= load_rest;
            cnt         <= CNT_TOP;
            Sout        <= load_bit;
            Sout_valid  <= 1'b1;
            Frame_start <= 1'b1;
            Last        <= 1'b0;
            Busy        <= 1'b1;
          end else begin
            state       <= IDLE;
            sreg        <= '0;
            Sout        <= IDLE_LEVEL;
            Sout_valid  <= 1'b0;
            Frame_start <= 1'b0;
            Last        <= 1'b0;
            Busy        <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances
// against a queue-of-pending-bits reference model.
module tb_piso_serializer;

  logic       Clk;
  logic       Rst;
  logic       En;
  logic [7:0] Din;
  logic       Load_valid;

  logic rdy_m, so_m, sv_m, fs_m, la_m, bu_m;
  logic rdy_l, so_l, sv_l, fs_l, la_l, bu_l;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] w;
    int         idx;
  } slot_t;

  slot_t pend[$];
  slot_t cur;
  bit    cv;

  piso_serializer #(
    .WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)
  ) u_msb (
    .Clk(Clk), .Rst(Rst), .En(En), .Din(Din),
    .Load_valid(Load_valid), .Load_ready(rdy_m),
    .Sout(so_m), .Sout_valid(sv_m),
    .Frame_start(fs_m), .Last(la_m), .Busy(bu_m)
  );

  piso_serializer #(
    .WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)
  ) u_lsb (
    .Clk(Clk), .Rst(Rst), .En(En), .Din(Din),
    .Load_valid(Load_valid), .Load_ready(rdy_l),
    .Sout(so_l), .Sout_valid(sv_l),
    .Frame_start(fs_l), .Last(la_l), .Busy(bu_l)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // One clock: drive, check ready, advance model, check outputs.
  task automatic step(input logic r, input logic e,
                      input logic [7:0] d, input logic v,
                      output bit acc);
    bit rdy;
    Rst = r;
    En = e;
    Din = d;
    Load_valid = v;
    #1;
    rdy = !r && e && (pend.size() == 0);
    chk("ready_m", 32'(rdy_m), 32'(rdy));
    chk("ready_l", 32'(rdy_l), 32'(rdy));
    acc = rdy && v;
    @(posedge Clk);
    if (r) begin
      pend.delete();
      cv = 1'b0;
    end else if (e) begin
      if (acc)
        for (int i = 0; i < 8; i++) pend.push_back('{d, i});
      if (pend.size() > 0) begin
        cur = pend.pop_front();
        cv = 1'b1;
      end else begin
        cv = 1'b0;
      end
    end
    @(negedge Clk);
    chk("sout_m", 32'(so_m), 32'(cv ? cur.w[7 - cur.idx] : 1'b0));
    chk("sout_l", 32'(so_l), 32'(cv ? cur.w[cur.idx] : 1'b1));
    chk("valid_m", 32'(sv_m), 32'(cv));
    chk("valid_l", 32'(sv_l), 32'(cv));
    chk("fs_m", 32'(fs_m), 32'(cv && cur.idx == 0));
    chk("fs_l", 32'(fs_l), 32'(cv && cur.idx == 0));
    chk("last_m", 32'(la_m), 32'(cv && cur.idx == 7));
    chk("last_l", 32'(la_l), 32'(cv && cur.idx == 7));
    chk("busy_m", 32'(bu_m), 32'(cv));
    chk("busy_l", 32'(bu_l), 32'(cv));
  endtask

  task automatic send(input logic [7:0] w);
    bit acc;
    int n;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 20) begin
      step(1'b0, 1'b1, w, 1'b1, acc);
      n++;
    end
    chk("accept", 32'(acc), 32'd1);
  endtask

  task automatic run(input int n, input logic e);
    bit acc;
    for (int i = 0; i < n; i++)
      step(1'b0, e, 8'($urandom), 1'b0, acc);
  endtask

  initial begin
    bit         acc;
    bit         pv;
    logic [7:0] pd;
    cv = 1'b0;
    Rst = 1'b1;
    En = 1'b1;
    Din = '0;
    Load_valid = 1'b0;

    // reset for two cycles, then idle
    step(1'b1, 1'b1, 8'h00, 1'b0, acc);
    step(1'b1, 1'b1, 8'h5A, 1'b1, acc);
    chk("rst_noacc", 32'(acc), 32'd0);
    run(2, 1'b1);

    // single words, both bit orders observed
    send(8'hA5);
    run(9, 1'b1);
    send(8'h01);
    run(9, 1'b1);

    // back-to-back frames with valid held
    send(8'hF0);
    send(8'h0F);
    run(9, 1'b1);

    // enable gap after bit 3 stretches it
    send(8'hA5);
    run(2, 1'b1);
    run(3, 1'b0);
    run(7, 1'b1);

    // reset mid-frame, then a clean word
    send(8'hFF);
    run(3, 1'b1);
    step(1'b1, 1'b1, 8'h81, 1'b1, acc);
    send(8'h81);
    run(9, 1'b1);

    // randomized traffic with a well-behaved producer
    pv = 1'b0;
    pd = '0;
    for (int c = 0; c < 600; c++) begin
      if (!pv && ($urandom_range(0, 2) != 0)) begin
        pv = 1'b1;
        pd = 8'($urandom);
      end
      step(($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < 80),
           pv ? pd : 8'($urandom), pv, acc);
      if (acc) pv = 1'b0;
    end
    run(12, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
